// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor. Each stage adds one CHUNK-bit
// slice with 4-bit lookahead groups; the slice carry is registered between
// stages and the whole pipe stalls together under valid/ready back-pressure.
// Ports: clk, rst_n (async, active low); in_valid/in_ready, A, B, CIN, SUB
// (1 = A-B, CIN ignored); out_valid/out_ready, SUM, COUT (1 = no borrow in
// SUB mode), OVF (signed overflow).
module pipelined_cla_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int NG    = (CHUNK + 3) / 4;
  localparam int NB    = NG * 4;

  if ((WIDTH % STAGES) != 0) begin : g_bad_split
    $error("pipelined_cla_addsub: WIDTH must be a multiple of STAGES");
  end

  // Two-level lookahead: flat sum-of-products group carries, then flat
  // sum-of-products bit carries inside each group. Returns {cout, sum}.
  function automatic logic [CHUNK:0] f_cla(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             ci
  );
    logic [NB-1:0] g;
    logic [NB-1:0] p;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   gc;
    logic [NB:0]   c;
    logic          t;
    logic          acc;
    g   = NB'(a & b);
    p   = NB'(a ^ b);
    gg  = '0;
    gp  = '1;
    gc  = '0;
    c   = '0;
    t   = 1'b0;
    acc = 1'b0;
    for (int j = 0; j < NG; j++) begin
      for (int k = 0; k < 4; k++) begin
        t = g[4*j+k];
        for (int n = k + 1; n < 4; n++) t = t & p[4*j+n];
        gg[j] = gg[j] | t;
        gp[j] = gp[j] & p[4*j+k];
      end
    end
    gc[0] = ci;
    for (int j = 1; j <= NG; j++) begin
      acc = 1'b0;
      for (int k = 0; k < j; k++) begin
        t = gg[k];
        for (int n = k + 1; n < j; n++) t = t & gp[n];
        acc = acc | t;
      end
      t = ci;
      for (int n = 0; n < j; n++) t = t & gp[n];
      gc[j] = acc | t;
    end
    for (int j = 0; j < NG; j++) begin
      for (int k = 0; k < 4; k++) begin
        acc = 1'b0;
        for (int m = 0; m < k; m++) begin
          t = g[4*j+m];
          for (int n = m + 1; n < k; n++) t = t & p[4*j+n];
          acc = acc | t;
        end
        t = gc[j];
        for (int n = 0; n < k; n++) t = t & p[4*j+n];
        c[4*j+k] = acc | t;
      end
    end
    c[NB] = gc[NG];
    return {c[CHUNK], p[CHUNK-1:0] ^ c[CHUNK-1:0]};
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_bm;
  logic             w_c0;
  logic             w_ovf;
  logic             r_ovf;

  assign w_adv    = !out_valid | out_ready;
  assign in_ready = w_adv;

  // Subtract as A + ~B + 1; CIN only matters in add mode.
  assign w_bm = SUB ? ~B : B;
  assign w_c0 = SUB ? 1'b1 : CIN;

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO  = s * CHUNK;
    localparam int REM = WIDTH - (s + 1) * CHUNK;

    logic [CHUNK-1:0]    w_a;
    logic [CHUNK-1:0]    w_b;
    logic [CHUNK-1:0]    w_s;
    logic                w_ci;
    logic                w_co;
    logic                w_vi;
    logic [LO+CHUNK-1:0] w_sn;
    logic [LO+CHUNK-1:0] r_s;
    logic                r_c;
    logic                r_v;

    assign {w_co, w_s} = f_cla(w_a, w_b, w_ci);

    if (s == 0) begin : g_src
      assign w_a  = A[CHUNK-1:0];
      assign w_b  = w_bm[CHUNK-1:0];
      assign w_ci = w_c0;
      assign w_vi = in_valid;
      assign w_sn = w_s;
    end else begin : g_src
      assign w_a  = g_st[s-1].g_al.r_a[CHUNK-1:0];
      assign w_b  = g_st[s-1].g_al.r_b[CHUNK-1:0];
      assign w_ci = g_st[s-1].r_c;
      assign w_vi = g_st[s-1].r_v;
      assign w_sn = {w_s, g_st[s-1].r_s};
    end

    // Operand slices not yet added ride along until their stage.
    if (s < STAGES - 1) begin : g_al
      logic [REM-1:0] w_an;
      logic [REM-1:0] w_bn;
      logic [REM-1:0] r_a;
      logic [REM-1:0] r_b;
      if (s == 0) begin : g_n
        assign w_an = A[WIDTH-1:CHUNK];
        assign w_bn = w_bm[WIDTH-1:CHUNK];
      end else begin : g_n
        assign w_an = g_st[s-1].g_al.r_a[REM+CHUNK-1:CHUNK];
        assign w_bn = g_st[s-1].g_al.r_b[REM+CHUNK-1:CHUNK];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_an;
          r_b <= w_bn;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_vi;
        r_c <= w_co;
        r_s <= w_sn;
      end
    end
  end

  // Carry into the MSB recovered from the MSB sum bit: a ^ b ^ s.
  assign w_ovf = g_st[STAGES-1].w_co
               ^ g_st[STAGES-1].w_a[CHUNK-1]
               ^ g_st[STAGES-1].w_b[CHUNK-1]
               ^ g_st[STAGES-1].w_s[CHUNK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_ovf;
    end
  end

  assign out_valid = g_st[STAGES-1].r_v;
  assign SUM       = g_st[STAGES-1].r_s;
  assign COUT      = g_st[STAGES-1].r_c;
  assign OVF       = r_ovf;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub: directed vectors, stalled and
// random streams, mid-flight reset, and a small parameter sweep.
module tb_pipelined_cla_addsub;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [63:0] sum;
  } res_t;

  localparam int SWN = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] A;
  logic [63:0] B;
  logic        CIN;
  logic        SUB;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] SUM;
  logic        COUT;
  logic        OVF;

  logic [31:0] sw_a;
  logic [31:0] sw_b;
  logic        sw_cin;
  logic        sw_sub;
  logic        sw_v;
  logic        sw_or;

  logic        r1_ir, r1_v, r1_c, r1_o;
  logic [15:0] r1_s;
  logic        r2_ir, r2_v, r2_c, r2_o;
  logic [15:0] r2_s;
  logic        r4_ir, r4_v, r4_c, r4_o;
  logic [15:0] r4_s;
  logic        r8_ir, r8_v, r8_c, r8_o;
  logic [31:0] r8_s;

  logic [31:0] ha [SWN];
  logic [31:0] hb [SWN];
  logic        hs [SWN];
  logic        hc [SWN];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_cla_addsub dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .CIN(CIN), .SUB(SUB),
    .out_valid(out_valid), .out_ready(out_ready),
    .SUM(SUM), .COUT(COUT), .OVF(OVF)
  );

  pipelined_cla_addsub #(.WIDTH(16), .STAGES(1)) d16s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_v), .in_ready(r1_ir),
    .A(sw_a[15:0]), .B(sw_b[15:0]), .CIN(sw_cin), .SUB(sw_sub),
    .out_valid(r1_v), .out_ready(sw_or),
    .SUM(r1_s), .COUT(r1_c), .OVF(r1_o)
  );

  pipelined_cla_addsub #(.WIDTH(16), .STAGES(2)) d16s2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_v), .in_ready(r2_ir),
    .A(sw_a[15:0]), .B(sw_b[15:0]), .CIN(sw_cin), .SUB(sw_sub),
    .out_valid(r2_v), .out_ready(sw_or),
    .SUM(r2_s), .COUT(r2_c), .OVF(r2_o)
  );

  pipelined_cla_addsub #(.WIDTH(16), .STAGES(4)) d16s4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_v), .in_ready(r4_ir),
    .A(sw_a[15:0]), .B(sw_b[15:0]), .CIN(sw_cin), .SUB(sw_sub),
    .out_valid(r4_v), .out_ready(sw_or),
    .SUM(r4_s), .COUT(r4_c), .OVF(r4_o)
  );

  pipelined_cla_addsub #(.WIDTH(32), .STAGES(8)) d32s8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_v), .in_ready(r8_ir),
    .A(sw_a), .B(sw_b), .CIN(sw_cin), .SUB(sw_sub),
    .out_valid(r8_v), .out_ready(sw_or),
    .SUM(r8_s), .COUT(r8_c), .OVF(r8_o)
  );

  // Reference: plain modular arithmetic on w bits plus the signed-range rule.
  function automatic res_t ref_op(int w, logic [63:0] a, logic [63:0] b,
                                  logic cin, logic sub);
    logic [64:0] m;
    logic [64:0] r;
    logic [63:0] am;
    logic [63:0] bm;
    logic        sa;
    logic        sb;
    logic        sr;
    res_t        o;
    m  = (65'd1 << w) - 65'd1;
    am = a & m[63:0];
    bm = (sub ? ~b : b) & m[63:0];
    r  = {1'b0, am} + {1'b0, bm} + {64'd0, (sub ? 1'b1 : cin)};
    sa = a[w-1];
    sb = b[w-1];
    sr = r[w-1];
    o.sum  = r[63:0] & m[63:0];
    o.cout = r[w];
    o.ovf  = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return o;
  endfunction

  function automatic res_t mk(logic ovf, logic cout, logic [63:0] sum);
    res_t o;
    o.ovf  = ovf;
    o.cout = cout;
    o.sum  = sum;
    return o;
  endfunction

  task automatic chkb(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated transaction: bubbles before, result at latency 4, bubble after.
  task automatic single(string tag, logic [63:0] a, logic [63:0] b,
                        logic cin, logic sub, res_t e);
    A = a;
    B = b;
    CIN = cin;
    SUB = sub;
    in_valid = 1'b1;
    out_ready = 1'b1;
    chkb({tag, "_in_ready"}, in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (i < 3) chkb({tag, "_early"}, out_valid, 1'b0);
    end
    chkb({tag, "_valid"}, out_valid, 1'b1);
    chkw({tag, "_sum"}, SUM, e.sum);
    chkb({tag, "_cout"}, COUT, e.cout);
    chkb({tag, "_ovf"}, OVF, e.ovf);
    @(posedge clk);
    #1;
    chkb({tag, "_one_cycle"}, out_valid, 1'b0);
  endtask

  // Stream n transactions through a scoreboard; rnd picks random back-pressure,
  // otherwise out_ready drops on cycles 6-8.
  task automatic stream(string tag, int n, bit rnd);
    res_t q[$];
    res_t e;
    int   sent;
    int   got;
    int   cyc;
    logic fin;
    logic stall;
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 300) begin
      stall = rnd ? ($urandom_range(0, 3) == 0) : (cyc >= 6 && cyc <= 8);
      out_ready = !stall;
      in_valid = (sent < n);
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      CIN = 1'($urandom_range(0, 1));
      SUB = 1'($urandom_range(0, 1));
      #1;
      if (!rnd && stall) begin
        chkb({tag, "_stall_in_ready"}, in_ready, 1'b0);
        chkb({tag, "_stall_out_valid"}, out_valid, 1'b1);
      end
      if (out_valid && stall) chkb({tag, "_hold_in_ready"}, in_ready, 1'b0);
      if (!out_valid) chkb({tag, "_idle_in_ready"}, in_ready, 1'b1);
      if (out_valid) begin
        chkb({tag, "_expected_pending"}, q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          chkw({tag, "_sum"}, SUM, q[0].sum);
          chkb({tag, "_cout"}, COUT, q[0].cout);
          chkb({tag, "_ovf"}, OVF, q[0].ovf);
          if (out_ready) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      fin = in_valid && in_ready;
      e = ref_op(64, A, B, CIN, SUB);
      @(posedge clk);
      #1;
      if (fin) begin
        q.push_back(e);
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chkw({tag, "_received"}, 64'(got), 64'(n));
    chkw({tag, "_leftover"}, 64'(q.size()), 64'd0);
  endtask

  task automatic check_sw(string tag, int w, int lat, int k, logic ir,
                          logic v, logic [31:0] s, logic c, logic o);
    int   idx;
    res_t e;
    idx = k - lat + 1;
    chkb({tag, "_in_ready"}, ir, 1'b1);
    if (idx >= 0 && idx < SWN) begin
      e = ref_op(w, {32'd0, ha[idx]}, {32'd0, hb[idx]}, hc[idx], hs[idx]);
      chkb({tag, "_valid"}, v, 1'b1);
      chkw({tag, "_sum"}, {32'd0, s}, e.sum);
      chkb({tag, "_cout"}, c, e.cout);
      chkb({tag, "_ovf"}, o, e.ovf);
    end else begin
      chkb({tag, "_bubble"}, v, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    CIN = 1'b0;
    SUB = 1'b0;
    sw_a = '0;
    sw_b = '0;
    sw_cin = 1'b0;
    sw_sub = 1'b0;
    sw_v = 1'b0;
    sw_or = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chkb("reset_out_valid", out_valid, 1'b0);
    chkb("reset_in_ready", in_ready, 1'b1);
    chkw("reset_sum", SUM, 64'd0);
    chkb("reset_cout", COUT, 1'b0);
    chkb("reset_ovf", OVF, 1'b0);
    rst_n = 1'b1;

    single("basic_add", 64'h170, 64'h608, 1'b0, 1'b0,
           mk(1'b0, 1'b0, 64'h778));
    single("carry_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           mk(1'b0, 1'b1, 64'h0));
    single("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           mk(1'b1, 1'b0, 64'h8000_0000_0000_0000));
    single("sub_borrow", 64'h5, 64'h7, 1'b1, 1'b1,
           mk(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE));
    single("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
           mk(1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF));
    single("add_cin", 64'hFFFF_FFFF_0000_FFFF, 64'h0, 1'b1, 1'b0,
           mk(1'b0, 1'b0, 64'hFFFF_FFFF_0001_0000));

    stream("b2b_stall", 8, 1'b0);
    stream("rnd_stream", 40, 1'b1);

    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chkb("midrst_out_valid", out_valid, 1'b0);
    chkw("midrst_sum", SUM, 64'd0);
    chkb("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chkb("midrst_no_stale", out_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    single("post_reset", ra, rb, 1'b1, 1'b0, ref_op(64, ra, rb, 1'b1, 1'b0));

    for (int k = 0; k < SWN + 8; k++) begin
      if (k < SWN) begin
        ha[k] = $urandom;
        hb[k] = $urandom;
        if (k % 8 == 4) begin
          ha[k] = 32'hFFFF_FFFF;
          hb[k] = 32'h1;
        end
        if (k % 8 == 3) begin
          ha[k] = 32'h8000_8000;
          hb[k] = 32'h1;
        end
        hs[k] = k[1];
        hc[k] = k[0];
        sw_a = ha[k];
        sw_b = hb[k];
        sw_sub = hs[k];
        sw_cin = hc[k];
        sw_v = 1'b1;
      end else begin
        sw_v = 1'b0;
      end
      @(posedge clk);
      #1;
      check_sw("w16_s1", 16, 1, k, r1_ir, r1_v, {16'd0, r1_s}, r1_c, r1_o);
      check_sw("w16_s2", 16, 2, k, r2_ir, r2_v, {16'd0, r2_s}, r2_c, r2_o);
      check_sw("w16_s4", 16, 4, k, r4_ir, r4_v, {16'd0, r4_s}, r4_c, r4_o);
      check_sw("w32_s8", 32, 8, k, r8_ir, r8_v, r8_s, r8_c, r8_o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
